// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: evaluates one conditional branch at a time, redirects fetch and flushes on taken.
// Optional macro BRANCH_UNSIGNED_EN enables bltu/bgeu (funct3 110/111); otherwise those encodings report illegal.
module branch_resolve_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic             res_valid_o,
  output logic             res_taken_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             flush_o,
  output logic             illegal_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] taken_count_o
);

  // state    | meaning
  // ST_IDLE  | ready for a new branch
  // ST_EVAL  | latched branch resolved, pulses driven for one cycle
  // ST_FLUSH | younger instructions killed while the flush counter runs down
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam bit         HAS_FLUSH  = (FLUSH_CYCLES != 0);
  localparam logic [3:0] FLUSH_LOAD = HAS_FLUSH ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;

  logic [XLEN-1:0]  rs1_q, rs2_q, pc_q, imm_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] br_count_q, taken_count_q;

  logic             accept;
  logic             op_eq;
  logic             op_lt_s;
  logic             cond_legal;
  logic             cond_true;
  logic             eval_taken;
  logic             target_aligned;
  logic             do_redirect;
  logic [XLEN-1:0]  target;

`ifdef BRANCH_UNSIGNED_EN
  logic             op_lt_u;
  assign op_lt_u = (rs1_q < rs2_q);
`endif

  assign accept         = req_valid_i && (state_q == ST_IDLE);
  assign op_eq          = (rs1_q == rs2_q);
  assign op_lt_s        = ($signed(rs1_q) < $signed(rs2_q));
  assign target         = pc_q + imm_q;
  assign target_aligned = (target[1:0] == 2'b00);

  always_comb begin
    cond_legal = 1'b1;
    cond_true  = 1'b0;
    case (funct3_q)
      3'b000:  cond_true = op_eq;
      3'b001:  cond_true = !op_eq;
      3'b100:  cond_true = op_lt_s;
      3'b101:  cond_true = !op_lt_s;
`ifdef BRANCH_UNSIGNED_EN
      3'b110:  cond_true = op_lt_u;
      3'b111:  cond_true = !op_lt_u;
`endif
      default: cond_legal = 1'b0;
    endcase
  end

  assign eval_taken  = cond_legal && cond_true;
  assign do_redirect = (state_q == ST_EVAL) && eval_taken && target_aligned;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (do_redirect && HAS_FLUSH) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 4'd0) state_d = ST_IDLE;
        else                     flush_cnt_d = flush_cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state and latched operands only
  always_comb begin
    req_ready_o      = (state_q == ST_IDLE);
    res_valid_o      = (state_q == ST_EVAL);
    res_taken_o      = res_valid_o && eval_taken;
    redirect_valid_o = do_redirect;
    redirect_pc_o    = do_redirect ? target : redirect_pc_q;
    flush_o          = (state_q == ST_FLUSH);
    illegal_o        = res_valid_o && !cond_legal;
    misalign_o       = res_valid_o && eval_taken && !target_aligned;
    br_count_o       = br_count_q;
    taken_count_o    = taken_count_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      pc_q     <= '0;
      imm_q    <= '0;
      funct3_q <= 3'b000;
    end else if (accept) begin
      rs1_q    <= rs1_i;
      rs2_q    <= rs2_i;
      pc_q     <= pc_i;
      imm_q    <= imm_i;
      funct3_q <= funct3_i;
    end
  end

  // Redirect target is held so downstream can sample it after the pulse
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      redirect_pc_q <= '0;
    end else if (do_redirect) begin
      redirect_pc_q <= target;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else if (state_q == ST_EVAL) begin
      if (br_count_q != '1) br_count_q <= br_count_q + CNT_W'(1);
      if (eval_taken && (taken_count_q != '1)) taken_count_q <= taken_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: cycle-schedule reference model, per-cycle compare, directed vectors.
module tb_branch_resolve_ctrl;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   rs1, rs2, pc, imm;
  logic [2:0]    funct3;
  logic          res_valid, res_taken, redirect_valid, flush, illegal, misalign;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] br_count, taken_count;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3), .pc_i(pc), .imm_i(imm),
    .res_valid_o(res_valid), .res_taken_o(res_taken), .redirect_valid_o(redirect_valid),
    .redirect_pc_o(redirect_pc), .flush_o(flush), .illegal_o(illegal), .misalign_o(misalign),
    .br_count_o(br_count), .taken_count_o(taken_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: schedule of when each effect of an accepted branch must appear
  bit          mv = 1'b0;
  int          free_at = 0, eval_at = -1, fl_lo = 0, fl_hi = -1;
  bit          e_taken, e_ill, e_mis, e_red;
  logic [31:0] e_tgt, last_pc;
  int          m_br, m_tk;

  function automatic void predict(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  output bit legal, output bit cond);
    legal = 1'b1;
    cond  = 1'b0;
    case (f3)
      3'b000: cond = (a == b);
      3'b001: cond = (a != b);
      3'b100: cond = ($signed(a) < $signed(b));
      3'b101: cond = ($signed(a) >= $signed(b));
`ifdef BRANCH_UNSIGNED_EN
      3'b110: cond = (a < b);
      3'b111: cond = (a >= b);
`endif
      default: legal = 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit legal, cond;
    if (reset) begin
      mv = 1'b1; free_at = cyc + 1; eval_at = -1; fl_lo = 0; fl_hi = -1;
      m_br = 0; m_tk = 0; last_pc = '0;
      e_taken = 0; e_ill = 0; e_mis = 0; e_red = 0; e_tgt = '0;
    end else if (mv) begin
      if (cyc == eval_at) begin
        if (m_br < CMAX) m_br++;
        if (e_taken && m_tk < CMAX) m_tk++;
        if (e_red) last_pc = e_tgt;
      end
      if (req_valid && cyc >= free_at) begin
        predict(funct3, rs1, rs2, legal, cond);
        e_ill   = !legal;
        e_taken = legal && cond;
        e_tgt   = pc + imm;
        e_red   = e_taken && (e_tgt[1:0] == 2'b00);
        e_mis   = e_taken && (e_tgt[1:0] != 2'b00);
        eval_at = cyc + 1;
        if (e_red && FC > 0) begin
          fl_lo = cyc + 2; fl_hi = cyc + 1 + FC; free_at = cyc + 2 + FC;
        end else begin
          fl_hi = -1; free_at = cyc + 2;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit ev;
    if (mv) begin
      ev = (cyc == eval_at);
      check("req_ready", req_ready, cyc >= free_at);
      check("res_valid", res_valid, ev);
      if (ev) check("res_taken", res_taken, e_taken);
      check("redirect_valid", redirect_valid, ev && e_red);
      check("redirect_pc", redirect_pc, (ev && e_red) ? e_tgt : last_pc);
      check("flush", flush, (cyc >= fl_lo) && (cyc <= fl_hi));
      check("illegal", illegal, ev && e_ill);
      check("misalign", misalign, ev && e_mis);
      check("br_count", br_count, m_br);
      check("taken_count", taken_count, m_tk);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return one step after the accepting edge (the EVAL cycle)
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, input logic [31:0] i, input bit keep);
    int n = 0;
    funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: req_ready got 0, expected 1 within 40 cycles (cycle %0d)", cyc);
      req_valid = 1'b0;
      return;
    end
    step();
    if (!keep) req_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, p, i;
  } vec_t;

  vec_t vecs[8] = '{
    '{3'b000, 32'h1, 32'h2, 32'h1000, 32'h10},
    '{3'b001, 32'h1, 32'h2, 32'h1000, 32'hFFFF_FFF0},
    '{3'b100, 32'h1, 32'hFFFF_FFFF, 32'h40, 32'h8},
    '{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h40, 32'h8},
    '{3'b101, 32'h5, 32'h5, 32'h80, 32'h6},
    '{3'b111, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h4},
    '{3'b011, 32'h3, 32'h3, 32'h200, 32'h4},
    '{3'b110, 32'h1, 32'hFFFF_FFFF, 32'h300, 32'hC}
  };

  initial begin
    int a_eval, b_eval;
    bit exp_ill_110;
`ifdef BRANCH_UNSIGNED_EN
    exp_ill_110 = 1'b0;
`else
    exp_ill_110 = 1'b1;
`endif
    reset = 1'b1; req_valid = 1'b0;
    rs1 = '0; rs2 = '0; pc = '0; imm = '0; funct3 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_flush", flush, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_br_count", br_count, 0);

    // beq taken, aligned
    send(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0);
    check("t1_res_valid", res_valid, 1);
    check("t1_res_taken", res_taken, 1);
    check("t1_redirect_valid", redirect_valid, 1);
    check("t1_redirect_pc", redirect_pc, 32'h120);
    step();
    check("t1_flush_n2", flush, 1);
    check("t1_ready_n2", req_ready, 0);
    check("t1_taken_count", taken_count, 1);
    step();
    check("t1_flush_n3", flush, 1);
    step();
    check("t1_flush_n4", flush, 0);
    check("t1_ready_n4", req_ready, 1);

    // bne not taken
    send(3'b001, 32'h7, 32'h7, 32'h100, 32'h20, 1'b0);
    check("t2_res_taken", res_taken, 0);
    check("t2_redirect_valid", redirect_valid, 0);
    step();
    check("t2_ready_n2", req_ready, 1);
    check("t2_br_count", br_count, 2);
    check("t2_taken_count", taken_count, 1);

    // signed compares and target wrap
    send(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8, 1'b0);
    check("t3_blt_taken", res_taken, 1);
    send(3'b101, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8, 1'b0);
    check("t3_bge_taken", res_taken, 0);
    send(3'b100, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0, 32'h20, 1'b0);
    check("t3_wrap_pc", redirect_pc, 32'h10);

    // unsigned encodings and reserved funct3
    send(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h400, 32'h8, 1'b0);
    check("t4_110_taken", res_taken, 0);
    check("t4_110_illegal", illegal, exp_ill_110);
    check("t4_110_redirect", redirect_valid, 0);
    send(3'b010, 32'h1, 32'h1, 32'h400, 32'h8, 1'b0);
    check("t4_010_illegal", illegal, 1);
    check("t4_010_valid", res_valid, 1);

    // misaligned taken target
    send(3'b000, 32'h3, 32'h3, 32'h100, 32'h22, 1'b0);
    check("t5_misalign", misalign, 1);
    check("t5_redirect_valid", redirect_valid, 0);
    step();
    check("t5_flush", flush, 0);
    check("t5_ready", req_ready, 1);

    foreach (vecs[k]) send(vecs[k].f3, vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].i, 1'b0);

    // back-to-back: second request held valid through EVAL/FLUSH
    send(3'b000, 32'h9, 32'h9, 32'h500, 32'h40, 1'b1);
    a_eval = cyc;
    send(3'b001, 32'h1, 32'h2, 32'h600, 32'h4, 1'b0);
    b_eval = cyc;
    check("b2b_spacing", b_eval - a_eval, 4);

    // saturate both counters
    for (int k = 0; k < 16; k++) send(3'b001, k, k + 1, 32'h0, 32'h8, 1'b0);
    step();
    check("sat_br_count", br_count, 15);
    check("sat_taken_count", taken_count, 15);

    // reset during the first flush cycle, with a request still pending
    send(3'b000, 32'h4, 32'h4, 32'h700, 32'h10, 1'b1);
    step();
    check("t6_flush_before", flush, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_flush_after", flush, 0);
    check("t6_ready_after", req_ready, 1);
    check("t6_br_count", br_count, 0);
    check("t6_taken_count", taken_count, 0);
    send(3'b000, 32'h9, 32'h9, 32'h40, 32'h10, 1'b0);
    check("t6_redirect_pc", redirect_pc, 32'h50);

    repeat (6) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequencing controller for branch resolution in the pipelined core.
- Accepts one conditional branch at a time over a valid/ready handshake and evaluates the RISC-V branch condition selected by funct3.
- Computes the target (pc + imm). On a taken branch, issues a one-cycle redirect and then asserts a pipeline flush for a programmable number of cycles.
- Keeps saturating branch/taken statistics counters for performance debug.

Parameters:
XLEN, 32, operand/PC width
FLUSH_CYCLES, 2, cycles flush held high after a taken redirect (0..15; 0 = no flush phase)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  branch request valid
req_ready  out  1  controller can accept a request
rs1  in  XLEN  first compare operand
rs2  in  XLEN  second compare operand
funct3  in  3  branch type
pc  in  XLEN  PC of the branch instruction
imm  in  XLEN  sign-extended B-type offset
res_valid  out  1  one-cycle pulse: branch resolved
res_taken  out  1  condition result, qualified by res_valid
redirect_valid  out  1  one-cycle pulse: fetch must jump
redirect_pc  out  XLEN  target, qualified by redirect_valid
flush  out  1  kill younger instructions
illegal  out  1  one-cycle pulse: unsupported funct3
misalign  out  1  one-cycle pulse: taken target not 4-byte aligned
br_count  out  CNT_W  resolved branches, saturating
taken_count  out  CNT_W  taken branches, saturating

Behaviour:
Reset:
- Registers: state=IDLE, all pulses 0, flush=0, redirect_pc=0, counters=0.
- Outputs: req_ready=1 in the cycle after reset deasserts.
- Reset takes effect from any state, including mid-FLUSH; the flush drops in the next cycle.

IDLE:
- req_ready=1.
- On req_valid && req_ready: latch rs1, rs2, funct3, pc, imm, then go to EVAL.
- req_valid without an accept is ignored.

EVAL (exactly 1 cycle, cycle N+1 after the accept at N):
- req_ready=0.
- Condition by funct3:
  - 000: equal
  - 001: not equal
  - 100: signed less-than
  - 101: signed greater-or-equal
- 010, 011: illegal=1, res_taken=0.
- 110, 111: handled per the optional feature.
- target = latched pc + imm, modulo 2^XLEN (wrap-around, no overflow flag).
- res_valid=1 for every accepted request, including illegal ones.
- Taken with target[1:0]==0: redirect_valid=1, redirect_pc=target, next state FLUSH (or IDLE if FLUSH_CYCLES==0).
- Taken with target[1:0]!=0: misalign=1, no redirect, no flush, next state IDLE.
- Not taken or illegal: next state IDLE.

FLUSH:
- flush=1 for exactly FLUSH_CYCLES consecutive cycles (cycles N+2 .. N+1+FLUSH_CYCLES), with req_ready=0.
- Down-counter loaded in EVAL; returns to IDLE when the counter reaches 0.

Counters:
- Updated in EVAL only.
- br_count += 1 for every accepted request.
- taken_count += 1 when res_taken=1, including misaligned.
- Both hold at all-ones (saturate, no wrap).

Timing and outputs:
- Outputs are registered-state decodes. No combinational path from inputs to outputs, except req_ready, which depends on state only.
- Throughput: 1 branch per 2 cycles (not taken), or per 2+FLUSH_CYCLES cycles (taken).
- redirect_pc holds its last value when redirect_valid=0.

Optional Feature:
Macro BRANCH_UNSIGNED_EN.
- Defined: funct3 110 = unsigned less-than (bltu), 111 = unsigned greater-or-equal (bgeu). Both are fully legal, with the same redirect, flush and counter behaviour as the other branch types.
- Undefined: 110 and 111 are treated like 010/011: illegal=1, res_taken=0, no redirect, br_count still increments.

Test Plan:
1. beq, rs1=rs2=0x5, pc=0x100, imm=0x20 -> EVAL cycle: res_valid=1, res_taken=1, redirect_valid=1, redirect_pc=0x120; flush=1 for exactly 2 cycles; req_ready returns 1 in cycle N+4; taken_count=1.
2. bne, rs1=rs2=0x7 -> res_taken=0, no redirect, no flush, req_ready=1 at N+2; br_count increments, taken_count does not.
3. blt, rs1=0xFFFFFFFF, rs2=0x1 -> taken. bge with the same operands -> not taken. pc=0xFFFFFFF0, imm=0x20 -> redirect_pc=0x10 (wrap).
4. funct3=110, rs1=0xFFFFFFFF, rs2=0x1:
   - with BRANCH_UNSIGNED_EN: res_taken=0, no illegal.
   - without BRANCH_UNSIGNED_EN: illegal=1, no redirect.
   - funct3=010: illegal=1 in both builds.
5. beq taken with imm=0x22 -> misalign=1, redirect_valid=0, flush=0, next state IDLE.
6. Reset asserted during the first flush cycle -> flush=0 and req_ready=1 next cycle, counters=0. A back-to-back request held valid through EVAL/FLUSH is accepted only after req_ready rises.
